// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FWFT FIFO and issues them as Wishbone pipelined requests.
// Latency: a command into an empty FIFO strobes next cycle; results are registered 1 cycle after ack.
// Backpressure: cmd_ready drops when the FIFO is full; issue pauses on alu_stall or at MAX_OUTSTANDING.

// Generic first-word-fall-through FIFO; caller guarantees no push when full, no pop when empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage write; contents need no reset because count alone decides validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

module alu_cmd_issuer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [7:0]  cmd_op,
  input  logic [17:0] cmd_al,
  input  logic [17:0] cmd_bl,
  input  logic [17:0] cmd_ar,
  input  logic [17:0] cmd_br,
  input  logic [47:0] cmd_cl,
  input  logic [47:0] cmd_cr,
  output logic        alu_cycle,
  output logic        alu_strobe,
  input  logic        alu_stall,
  input  logic        alu_ack,
  output logic        alu_mode,
  output logic [7:0]  alu_op,
  output logic [17:0] alu_al,
  output logic [17:0] alu_bl,
  output logic [17:0] alu_ar,
  output logic [17:0] alu_br,
  output logic [47:0] alu_cl,
  output logic [47:0] alu_cr,
  input  logic [47:0] alu_pl,
  input  logic [47:0] alu_pr,
  output logic        res_valid,
  output logic [47:0] res_pl,
  output logic [47:0] res_pr,
  output logic [3:0]  outstanding,
  output logic        err_ack
);

  typedef struct packed {
    logic        mode;
    logic [7:0]  op;
    logic [17:0] al;
    logic [17:0] bl;
    logic [17:0] ar;
    logic [17:0] br;
    logic [47:0] cl;
    logic [47:0] cr;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL    = CW'(FIFO_DEPTH);
  localparam logic [3:0]      MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t        state;
  state_t        state_nxt;
  cmd_t          cmd_in;
  cmd_t          head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [3:0]    out_nxt;
  logic          issuable_nxt;
  logic          push;
  logic          accept;
  logic          ack_ok;

  assign cmd_in    = {cmd_mode, cmd_op, cmd_al, cmd_bl, cmd_ar, cmd_br, cmd_cl, cmd_cr};
  // Held low through reset so nothing is offered to an upstream that is itself resetting
  assign cmd_ready = ~reset & (count != FULL);
  assign push      = cmd_valid & cmd_ready;

  // State is kept equal to "head issuable", so strobe comes straight from a register
  assign alu_strobe = (state == ISSUE);
  assign alu_cycle  = (state != IDLE);
  assign accept     = alu_strobe & ~alu_stall;
  assign ack_ok     = alu_ack & (outstanding != 4'd0);

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (accept),
    .wdata (cmd_in),
    .head  (head),
    .count (count)
  );

  assign alu_mode = head.mode;
  assign alu_op   = head.op;
  assign alu_al   = head.al;
  assign alu_bl   = head.bl;
  assign alu_ar   = head.ar;
  assign alu_br   = head.br;
  assign alu_cl   = head.cl;
  assign alu_cr   = head.cr;

  // Next-state from post-edge FIFO count and outstanding, so a fresh command strobes next cycle
  always_comb begin
    count_nxt = count;
    if (push && !accept)      count_nxt = count + CW'(1);
    else if (!push && accept) count_nxt = count - CW'(1);

    out_nxt = outstanding;
    if (accept && !ack_ok)      out_nxt = outstanding + 4'd1;
    else if (!accept && ack_ok) out_nxt = outstanding - 4'd1;

    issuable_nxt = (count_nxt != '0) && (out_nxt < MAX_OUT);

    state_nxt = state;
    case (state)
      IDLE:    if (issuable_nxt) state_nxt = ISSUE;
      ISSUE:   if (!issuable_nxt) state_nxt = (out_nxt != 4'd0) ? WAIT : IDLE;
      WAIT: begin
        if (issuable_nxt)           state_nxt = ISSUE;
        else if (out_nxt == 4'd0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, outstanding counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      outstanding <= 4'd0;
      err_ack     <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (alu_ack && outstanding == 4'd0) err_ack <= 1'b1;
    end
  end

  // Result capture; acks arrive in request order so no reordering is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_pl    <= '0;
      res_pr    <= '0;
    end else begin
      res_valid <= ack_ok;
      if (ack_ok) begin
        res_pl <= alu_pl;
        res_pr <= alu_pr;
      end
    end
  end

endmodule
